// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment scan decoder: segment bit positions,
// the hex glyph table (active-high, point excluded) and the capture FSM states.
package seven_segment_pkg;

  localparam int SEG_TOP          = 0;
  localparam int SEG_RIGHT_TOP    = 1;
  localparam int SEG_RIGHT_BOTTOM = 2;
  localparam int SEG_BOTTOM       = 3;
  localparam int SEG_LEFT_BOTTOM  = 4;
  localparam int SEG_LEFT_TOP     = 5;
  localparam int SEG_CENTER       = 6;
  localparam int SEG_POINT        = 7;

  localparam int GLYPH_COUNT = 16;

  // Entry i is the segment mask that displays hex digit i.
  localparam logic [6:0] GLYPH_MASK [GLYPH_COUNT] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLING = 2'd1,
    CAPTURED = 2'd2
  } state_t;

endpackage

// File: rtl/seven_segment_pattern_decoder.sv
// Combinational glyph lookup: active-high 8-bit segment mask in, hex value,
// decimal point and legal flag out. Value is 0 when the mask is not a glyph.
module seven_segment_pattern_decoder
  import seven_segment_pkg::*;
(
  input  logic [7:0] mask,
  output logic [3:0] value,
  output logic       point,
  output logic       legal
);

  always_comb begin
    value = 4'd0;
    legal = 1'b0;
    for (int i = 0; i < GLYPH_COUNT; i++) begin
      if (mask[SEG_CENTER:SEG_TOP] == GLYPH_MASK[i]) begin
        value = 4'(i);
        legal = 1'b1;
      end
    end
  end

  assign point = mask[SEG_POINT];

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Watches a multiplexed seven-segment drive, waits for a digit's pattern to be
// stable for STABLE_CYCLES samples, then latches the decoded glyph per digit.
module seven_segment_scan_decoder
  import seven_segment_pkg::*;
#(
  parameter int DIGIT_COUNT   = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [7:0]                       segmentEnableN,
  input  logic [DIGIT_COUNT-1:0]           digitEnableN,
  output logic [4*DIGIT_COUNT-1:0]         value,
  output logic [DIGIT_COUNT-1:0]           pointEnable,
  output logic [DIGIT_COUNT-1:0]           digitValid,
  output logic [DIGIT_COUNT-1:0]           patternError,
  output logic                             updateStrobe,
  output logic [$clog2(DIGIT_COUNT)-1:0]   updateDigit,
  output logic                             frameComplete
);

  localparam int IDX_W = $clog2(DIGIT_COUNT);
  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  state_t             state;
  logic [7:0]         count;
  logic [IDX_W-1:0]   stored_digit;
  logic [7:0]         stored_segments;
  logic [DIGIT_COUNT-1:0] bitmap;

  logic [3:0]         low_count;
  logic [IDX_W-1:0]   sample_digit;
  logic               selectable;
  logic               same;
  logic [7:0]         next_count;
  logic               capture;
  logic [DIGIT_COUNT-1:0] bitmap_next;

  logic [3:0]         glyph_value;
  logic               glyph_point;
  logic               glyph_legal;

  seven_segment_pattern_decoder u_pattern_decoder (
    .mask  (~segmentEnableN),
    .value (glyph_value),
    .point (glyph_point),
    .legal (glyph_legal)
  );

  always_comb begin
    low_count    = 4'd0;
    sample_digit = '0;
    for (int i = 0; i < DIGIT_COUNT; i++) begin
      if (!digitEnableN[i]) begin
        low_count    = low_count + 4'd1;
        sample_digit = IDX_W'(i);
      end
    end
  end

  assign selectable = (low_count == 4'd1);
  assign same       = (sample_digit == stored_digit) && (segmentEnableN == stored_segments);

  // The count saturates so a long-held pattern never wraps into a second capture.
  always_comb begin
    next_count = 8'd0;
    if (selectable) begin
      if (state != IDLE && same)
        next_count = (count == STABLE_MAX) ? count : count + 8'd1;
      else
        next_count = 8'd1;
    end
  end

  assign capture     = selectable && (next_count == STABLE_MAX) && !(state == CAPTURED && same);
  assign bitmap_next = bitmap | (DIGIT_COUNT'(1) << sample_digit);

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      count           <= 8'd0;
      stored_digit    <= '0;
      stored_segments <= 8'd0;
      bitmap          <= '0;
      value           <= '0;
      pointEnable     <= '0;
      digitValid      <= '0;
      patternError    <= '0;
      updateStrobe    <= 1'b0;
      updateDigit     <= '0;
      frameComplete   <= 1'b0;
    end else begin
      updateStrobe  <= 1'b0;
      frameComplete <= 1'b0;
      count         <= next_count;
      if (!selectable) begin
        state <= IDLE;
      end else begin
        stored_digit    <= sample_digit;
        stored_segments <= segmentEnableN;
        if (capture || (state == CAPTURED && same))
          state <= CAPTURED;
        else
          state <= SETTLING;
      end
      if (capture) begin
        updateStrobe <= 1'b1;
        updateDigit  <= sample_digit;
        if (&bitmap_next) begin
          frameComplete <= 1'b1;
          bitmap        <= '0;
        end else begin
          bitmap <= bitmap_next;
        end
      end
      // Illegal glyphs keep the previous value but still report point and error.
      for (int i = 0; i < DIGIT_COUNT; i++) begin
        if (capture && sample_digit == IDX_W'(i)) begin
          pointEnable[i]  <= glyph_point;
          digitValid[i]   <= glyph_legal;
          patternError[i] <= !glyph_legal;
          if (glyph_legal)
            value[4*i +: 4] <= glyph_value;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Directed bench for seven_segment_scan_decoder with DIGIT_COUNT=4, STABLE_CYCLES=4.
module tb_seven_segment_scan_decoder;
  import seven_segment_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  segmentEnableN = 8'hFF;
  logic [3:0]  digitEnableN = 4'hF;
  logic [15:0] value;
  logic [3:0]  pointEnable;
  logic [3:0]  digitValid;
  logic [3:0]  patternError;
  logic        updateStrobe;
  logic [1:0]  updateDigit;
  logic        frameComplete;

  int n_cmp = 0;
  int n_err = 0;
  int strobe_total = 0;
  int frame_total = 0;
  int strobe_base;
  int frame_base;

  seven_segment_scan_decoder #(.DIGIT_COUNT(4), .STABLE_CYCLES(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .segmentEnableN (segmentEnableN),
    .digitEnableN   (digitEnableN),
    .value          (value),
    .pointEnable    (pointEnable),
    .digitValid     (digitValid),
    .patternError   (patternError),
    .updateStrobe   (updateStrobe),
    .updateDigit    (updateDigit),
    .frameComplete  (frameComplete)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (updateStrobe) strobe_total++;
    if (frameComplete) frame_total++;
  end

  function automatic logic [7:0] pat(input logic [6:0] mask, input logic pt);
    return ~{pt, mask};
  endfunction

  task automatic step(input logic [3:0] dn, input logic [7:0] sn);
    digitEnableN   = dn;
    segmentEnableN = sn;
    @(posedge clock);
    #1;
  endtask

  task automatic hold(input int n, input logic [3:0] dn, input logic [7:0] sn);
    for (int i = 0; i < n; i++) step(dn, sn);
  endtask

  task automatic mark();
    strobe_base = strobe_total;
    frame_base  = frame_total;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    hold(2, 4'hF, 8'hFF);
    n_cmp++; if (value !== 16'h0) begin n_err++; $display("FAIL reset_value: got %h want 0000", value); end
    n_cmp++; if ({pointEnable, digitValid, patternError} !== 12'h0) begin n_err++; $display("FAIL reset_flags: got %h want 000", {pointEnable, digitValid, patternError}); end
    n_cmp++; if ({updateStrobe, updateDigit, frameComplete} !== 4'h0) begin n_err++; $display("FAIL reset_pulses: got %b want 0000", {updateStrobe, updateDigit, frameComplete}); end
    n_cmp++; if (dut.state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want IDLE", dut.state); end
    reset = 1'b0;
    step(4'hF, 8'hFF);
  endtask

  task automatic test_basic_capture();
    mark();
    hold(4, 4'b1101, pat(7'h5B, 1'b0));
    n_cmp++; if (updateStrobe !== 1'b1) begin n_err++; $display("FAIL basic_strobe: got %b want 1", updateStrobe); end
    n_cmp++; if (updateDigit !== 2'd1) begin n_err++; $display("FAIL basic_digit: got %0d want 1", updateDigit); end
    n_cmp++; if (value[7:4] !== 4'h2) begin n_err++; $display("FAIL basic_value: got %h want 2", value[7:4]); end
    n_cmp++; if (digitValid[1] !== 1'b1 || patternError[1] !== 1'b0 || pointEnable[1] !== 1'b0) begin n_err++; $display("FAIL basic_flags: got v%b e%b p%b want v1 e0 p0", digitValid[1], patternError[1], pointEnable[1]); end
    step(4'b1101, pat(7'h5B, 1'b0));
    n_cmp++; if (updateStrobe !== 1'b0 || updateDigit !== 2'd1) begin n_err++; $display("FAIL basic_one_cycle: got s%b d%0d want s0 d1", updateStrobe, updateDigit); end
    step(4'hF, 8'hFF);
    n_cmp++; if (strobe_total - strobe_base !== 1) begin n_err++; $display("FAIL basic_count: got %0d want 1", strobe_total - strobe_base); end
  endtask

  task automatic test_restart();
    mark();
    hold(3, 4'b1110, pat(7'h4F, 1'b0));
    hold(4, 4'b1110, pat(7'h66, 1'b0));
    n_cmp++; if (value[3:0] !== 4'h4) begin n_err++; $display("FAIL restart_value: got %h want 4", value[3:0]); end
    n_cmp++; if (value[7:4] !== 4'h2) begin n_err++; $display("FAIL restart_other_digit: got %h want 2", value[7:4]); end
    step(4'hF, 8'hFF);
    n_cmp++; if (strobe_total - strobe_base !== 1) begin n_err++; $display("FAIL restart_count: got %0d want 1", strobe_total - strobe_base); end
  endtask

  task automatic test_illegal();
    mark();
    hold(4, 4'b1011, pat(7'h07, 1'b0));
    step(4'hF, 8'hFF);
    n_cmp++; if (value[11:8] !== 4'h7) begin n_err++; $display("FAIL illegal_pre_value: got %h want 7", value[11:8]); end
    hold(4, 4'b1011, pat(7'h00, 1'b1));
    n_cmp++; if (updateStrobe !== 1'b1 || updateDigit !== 2'd2) begin n_err++; $display("FAIL illegal_strobe: got s%b d%0d want s1 d2", updateStrobe, updateDigit); end
    n_cmp++; if (patternError[2] !== 1'b1 || digitValid[2] !== 1'b0) begin n_err++; $display("FAIL illegal_flags: got e%b v%b want e1 v0", patternError[2], digitValid[2]); end
    n_cmp++; if (value[11:8] !== 4'h7 || pointEnable[2] !== 1'b1) begin n_err++; $display("FAIL illegal_hold: got val %h p%b want 7 p1", value[11:8], pointEnable[2]); end
    n_cmp++; if (value[7:0] !== 8'h24 || digitValid[1:0] !== 2'b11) begin n_err++; $display("FAIL illegal_others: got %h v%b want 24 v11", value[7:0], digitValid[1:0]); end
    step(4'hF, 8'hFF);
    n_cmp++; if (strobe_total - strobe_base !== 2 || frame_total - frame_base !== 0) begin n_err++; $display("FAIL illegal_count: got s%0d f%0d want s2 f0", strobe_total - strobe_base, frame_total - frame_base); end
  endtask

  task automatic test_multi_select();
    mark();
    hold(10, 4'b1100, pat(7'h3F, 1'b0));
    n_cmp++; if (dut.state !== IDLE) begin n_err++; $display("FAIL multi_state: got %0d want IDLE", dut.state); end
    step(4'hF, 8'hFF);
    n_cmp++; if (strobe_total - strobe_base !== 0) begin n_err++; $display("FAIL multi_count: got %0d want 0", strobe_total - strobe_base); end
  endtask

  task automatic test_hold_long();
    mark();
    hold(20, 4'b0111, pat(7'h6D, 1'b0));
    n_cmp++; if (value[15:12] !== 4'h5) begin n_err++; $display("FAIL hold_value: got %h want 5", value[15:12]); end
    step(4'hF, 8'hFF);
    n_cmp++; if (strobe_total - strobe_base !== 1 || frame_total - frame_base !== 1) begin n_err++; $display("FAIL hold_count: got s%0d f%0d want s1 f1", strobe_total - strobe_base, frame_total - frame_base); end
  endtask

  task automatic test_frame();
    reset = 1'b1;
    step(4'hF, 8'hFF);
    reset = 1'b0;
    mark();
    hold(4, 4'b1110, pat(7'h06, 1'b0));
    hold(4, 4'b1110, pat(7'h6F, 1'b0));
    hold(4, 4'b1101, pat(7'h77, 1'b0));
    hold(4, 4'b1011, pat(7'h39, 1'b0));
    n_cmp++; if (frame_total - frame_base !== 0) begin n_err++; $display("FAIL frame_early: got %0d want 0", frame_total - frame_base); end
    hold(4, 4'b0111, pat(7'h71, 1'b0));
    n_cmp++; if (frameComplete !== 1'b1 || updateStrobe !== 1'b1 || updateDigit !== 2'd3) begin n_err++; $display("FAIL frame_pulse: got f%b s%b d%0d want f1 s1 d3", frameComplete, updateStrobe, updateDigit); end
    n_cmp++; if (value !== 16'hFCA9 || digitValid !== 4'hF) begin n_err++; $display("FAIL frame_value: got %h v%h want FCA9 vF", value, digitValid); end
    step(4'hF, 8'hFF);
    n_cmp++; if (frameComplete !== 1'b0) begin n_err++; $display("FAIL frame_one_cycle: got %b want 0", frameComplete); end
    n_cmp++; if (strobe_total - strobe_base !== 5 || frame_total - frame_base !== 1) begin n_err++; $display("FAIL frame_count: got s%0d f%0d want s5 f1", strobe_total - strobe_base, frame_total - frame_base); end
  endtask

  task automatic test_back_to_back();
    mark();
    hold(4, 4'b1110, pat(7'h3F, 1'b0));
    hold(4, 4'b1101, pat(7'h06, 1'b1));
    hold(4, 4'b1011, pat(7'h5B, 1'b0));
    hold(4, 4'b0111, pat(7'h4F, 1'b0));
    step(4'hF, 8'hFF);
    n_cmp++; if (value !== 16'h3210 || pointEnable !== 4'b0010) begin n_err++; $display("FAIL b2b_value: got %h p%b want 3210 p0010", value, pointEnable); end
    n_cmp++; if (strobe_total - strobe_base !== 4 || frame_total - frame_base !== 1) begin n_err++; $display("FAIL b2b_count: got s%0d f%0d want s4 f1", strobe_total - strobe_base, frame_total - frame_base); end
  endtask

  task automatic test_reset_abort();
    mark();
    hold(2, 4'b1101, pat(7'h5B, 1'b0));
    reset = 1'b1;
    step(4'b1101, pat(7'h5B, 1'b0));
    n_cmp++; if (value !== 16'h0 || {pointEnable, digitValid, patternError} !== 12'h0) begin n_err++; $display("FAIL abort_outputs: got %h %h want 0000 000", value, {pointEnable, digitValid, patternError}); end
    n_cmp++; if ({updateStrobe, updateDigit, frameComplete} !== 4'h0 || dut.state !== IDLE) begin n_err++; $display("FAIL abort_state: got %b st%0d want 0000 IDLE", {updateStrobe, updateDigit, frameComplete}, dut.state); end
    reset = 1'b0;
    hold(2, 4'b1101, pat(7'h5B, 1'b0));
    step(4'hF, 8'hFF);
    n_cmp++; if (strobe_total - strobe_base !== 0) begin n_err++; $display("FAIL abort_count: got %0d want 0", strobe_total - strobe_base); end
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_restart();
    test_illegal();
    test_multi_select();
    test_hold_long();
    test_frame();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
